multi_channel_sample_counter: RTL and testbench
===============================================

// Module: multi_channel_sample_counter
// PURPOSE
//  Parametrised per-channel sample-block counter for the FIR/SPI datapath.
//  Counts sample strobes per channel. Flags each completed block of (last_idx+1) samples.
//  Keeps a saturating count of completed blocks, with wrap or one-shot operation.
//  Sits between the sample-strobe sources and the control/status logic that reads done flags.
// PARAMETERS
//  NUM_CH        1   number of independent channels
//  CNT_BITS      10  width of per-channel sample counter and of last_idx
//  BLK_BITS      8   width of per-channel completed-block counter (saturating)
// PORTS
//  clk          in   1                  system clock, rising edge
//  n_rst        in   1                  asynchronous active-low reset
//  cnt_up       in   NUM_CH             per-channel sample strobe, one sample per high cycle
//  clear        in   NUM_CH             per-channel synchronous clear
//  ack          in   NUM_CH             per-channel sticky-flag acknowledge
//  one_shot     in   1                  0 = wrap mode, 1 = halt after each block
//  last_idx     in   CNT_BITS           terminal index; block length = last_idx+1
//  count        out  NUM_CH*CNT_BITS    current sample index, ch c at [c*CNT_BITS +: CNT_BITS]
//  done         out  NUM_CH             one-cycle block-complete pulse
//  done_sticky  out  NUM_CH             latched done, held until ack/clear
//  halted       out  NUM_CH             channel stopped (one-shot mode only)
//  blocks       out  NUM_CH*BLK_BITS    completed blocks, ch c at [c*BLK_BITS +: BLK_BITS]
// BEHAVIOUR
//  - Reset (n_rst=0, async): all count, blocks, done, done_sticky and halted are 0.
//  - Channels are fully independent. Only one_shot and last_idx are shared.
//  - Terminal strobe: a cycle with cnt_up[c]=1, halted[c]=0 and count[c] >= last_idx.
//    The >= comparison covers last_idx being lowered mid-block.
//  - Non-terminal strobe: count <= count+1.
//  - Terminal strobe, next edge:
//    - count <= 0.
//    - done <= 1 for exactly one cycle.
//    - done_sticky <= 1.
//    - blocks <= blocks+1, saturating at 2**BLK_BITS-1.
//    - halted <= one_shot.
//  - Latency: done is registered. It is high in the cycle after the (last_idx+1)th strobe.
//  - last_idx=0: every accepted strobe is terminal; done follows each strobe by one cycle.
//  - halted=1: cnt_up is ignored and count holds at 0.
//    Only clear[c] or reset releases halted.
//    Deasserting one_shot does not release halted.
//  - clear[c]=1, next edge:
//    - count, blocks, done_sticky and halted <= 0; done <= 0.
//    - clear has priority over a simultaneous cnt_up, terminal or not.
//  - ack[c]=1: done_sticky <= 0.
//    If a terminal strobe occurs in the same cycle, set wins (done_sticky=1).
//  - Back-to-back terminal strobes in wrap mode:
//    done stays high on consecutive cycles, and blocks increments each time.
//  - Reset asserted mid-block discards the partial count. No done is produced.
//  - All outputs come directly from flops. There are no combinational paths from inputs to outputs.
// TESTING
//  T1 NUM_CH=1, last_idx=999, one_shot=0, 1000 strobes
//     -> done high only in the cycle after strobe 1000; count=0; blocks=1; done_sticky=1.
//  T2 one_shot=1, last_idx=3, 6 strobes
//     -> done once after strobe 4; halted=1; count=0 after the extra strobes.
//     Then clear -> halted=0; a further strobe gives count=1.
//  T3 last_idx=0, continuous cnt_up for 5 cycles
//     -> done high 5 consecutive cycles; blocks=5.
//     With BLK_BITS=2, blocks saturates at 3.
//  T4 ack in the same cycle as a terminal strobe -> done_sticky=1.
//     ack alone on the next cycle -> done_sticky=0.
//  T5 clear with cnt_up in the same cycle at count=last_idx
//     -> no done pulse; count=0; blocks=0.
//  T6 NUM_CH=4, interleaved strobes on channels 0 and 2; n_rst pulsed low mid-block
//     -> no cross-channel interaction; all outputs 0 immediately on reset.
//     Lowering last_idx below count terminates on the next strobe.

Source files
------------

// File: rtl/multi_channel_sample_counter.sv
// Per-channel sample-block counter: counts strobes, pulses done on each completed
// block of last_idx+1 samples, and keeps a saturating completed-block count.
module multi_channel_sample_counter #(
  parameter int NUM_CH   = 1,
  parameter int CNT_BITS = 10,
  parameter int BLK_BITS = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_CH-1:0]            cnt_up,
  input  logic [NUM_CH-1:0]            clear,
  input  logic [NUM_CH-1:0]            ack,
  input  logic                         one_shot,
  input  logic [CNT_BITS-1:0]          last_idx,
  output logic [NUM_CH*CNT_BITS-1:0]   count,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            done_sticky,
  output logic [NUM_CH-1:0]            halted,
  output logic [NUM_CH*BLK_BITS-1:0]   blocks
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_BITS-1:0] cnt_q;
    logic [BLK_BITS-1:0] blk_q;
    logic                done_q;
    logic                sticky_q;
    logic                halt_q;
    logic                accept;
    logic                terminal;

    assign accept   = cnt_up[c] && !halt_q;
    // >= rather than == so a mid-block drop of last_idx still ends the block
    assign terminal = accept && (cnt_q >= last_idx);

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q    <= '0;
        blk_q    <= '0;
        done_q   <= 1'b0;
        sticky_q <= 1'b0;
        halt_q   <= 1'b0;
      end else if (clear[c]) begin
        cnt_q    <= '0;
        blk_q    <= '0;
        done_q   <= 1'b0;
        sticky_q <= 1'b0;
        halt_q   <= 1'b0;
      end else begin
        done_q <= terminal;
        if (ack[c]) sticky_q <= 1'b0;
        if (terminal) begin
          cnt_q    <= '0;
          sticky_q <= 1'b1;
          halt_q   <= one_shot;
          if (blk_q != {BLK_BITS{1'b1}}) blk_q <= blk_q + 1'b1;
        end else if (accept) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign count[c*CNT_BITS +: CNT_BITS] = cnt_q;
    assign blocks[c*BLK_BITS +: BLK_BITS] = blk_q;
    assign done[c]        = done_q;
    assign done_sticky[c] = sticky_q;
    assign halted[c]      = halt_q;
  end

endmodule

// File: tb/tb_multi_channel_sample_counter.sv
// Directed bench for multi_channel_sample_counter; done pulses are checked by a
// monitor against a queue of expected completions filled by the stimulus.
module tb_multi_channel_sample_counter;
  localparam int NCH = 4;
  localparam int CB  = 10;
  localparam int BB  = 2;

  logic               clk = 1'b0;
  logic               n_rst = 1'b0;
  logic [NCH-1:0]     cnt_up = '0, clear = '0, ack = '0;
  logic               one_shot = 1'b0;
  logic [CB-1:0]      last_idx = '0;
  logic [NCH*CB-1:0]  count;
  logic [NCH-1:0]     done, done_sticky, halted;
  logic [NCH*BB-1:0]  blocks;

  multi_channel_sample_counter #(.NUM_CH(NCH), .CNT_BITS(CB), .BLK_BITS(BB)) dut (
    .clk(clk), .n_rst(n_rst), .cnt_up(cnt_up), .clear(clear), .ack(ack),
    .one_shot(one_shot), .last_idx(last_idx), .count(count), .done(done),
    .done_sticky(done_sticky), .halted(halted), .blocks(blocks)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int blk; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int cnt(int c);
    return int'(count[c*CB +: CB]);
  endfunction

  function automatic int blk(int c);
    return int'(blocks[c*BB +: BB]);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expect a done pulse on channel ch with blocks == b once the edge lands
  task automatic expect_done(int ch, int b);
    exp_t e;
    e.ch = ch;
    e.blk = b;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NCH-1:0] cu, input logic [NCH-1:0] cl,
                      input logic [NCH-1:0] ak);
    cnt_up = cu; clear = cl; ack = ak;
    @(posedge clk);
    #1;
    cnt_up = '0; clear = '0; ack = '0;
  endtask

  // monitor: every done pulse must match the head of the expectation queue
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (done[c]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: ch %0d pulsed, expected no pulse (t=%0t)", c, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_channel", c, e.ch);
          check("done_blocks", blk(c), e.blk);
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_count", int'(count), 0);
    check("rst_blocks", int'(blocks), 0);
    check("rst_flags", int'({done, done_sticky, halted}), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // T1: 1000-sample block in wrap mode
    last_idx = 10'd999;
    for (int i = 0; i < 999; i++) step(4'b0001, 4'b0, 4'b0);
    check("t1_count_999", cnt(0), 999);
    check("t1_sticky_pre", int'(done_sticky[0]), 0);
    expect_done(0, 1);
    step(4'b0001, 4'b0, 4'b0);
    check("t1_count_wrap", cnt(0), 0);
    check("t1_blocks", blk(0), 1);
    check("t1_sticky", int'(done_sticky[0]), 1);
    step(4'b0, 4'b0, 4'b0);
    check("t1_done_low", int'(done[0]), 0);
    step(4'b0, 4'b0001, 4'b0);
    check("clr_sticky", int'(done_sticky[0]), 0);
    check("clr_blocks", blk(0), 0);

    // T2: one-shot halts after the block; only clear releases it
    one_shot = 1'b1;
    last_idx = 10'd3;
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0, 4'b0);
    expect_done(0, 1);
    step(4'b0001, 4'b0, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    check("t2_halted", int'(halted[0]), 1);
    check("t2_count_held", cnt(0), 0);
    one_shot = 1'b0;
    step(4'b0001, 4'b0, 4'b0);
    check("t2_still_halted", int'(halted[0]), 1);
    one_shot = 1'b1;
    step(4'b0, 4'b0001, 4'b0);
    check("t2_released", int'(halted[0]), 0);
    step(4'b0001, 4'b0, 4'b0);
    check("t2_count_1", cnt(0), 1);

    // T3: last_idx=0, continuous strobes, blocks saturates at 3
    one_shot = 1'b0;
    last_idx = 10'd0;
    step(4'b0, 4'b0001, 4'b0);
    expect_done(0, 1); step(4'b0001, 4'b0, 4'b0);
    expect_done(0, 2); step(4'b0001, 4'b0, 4'b0);
    expect_done(0, 3); step(4'b0001, 4'b0, 4'b0);
    expect_done(0, 3); step(4'b0001, 4'b0, 4'b0);
    expect_done(0, 3); step(4'b0001, 4'b0, 4'b0);
    step(4'b0, 4'b0, 4'b0);
    check("t3_blocks_sat", blk(0), 3);

    // T4: ack colliding with a terminal strobe loses to the set
    last_idx = 10'd2;
    step(4'b0, 4'b0001, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    expect_done(0, 1);
    step(4'b0001, 4'b0, 4'b0001);
    check("t4_set_wins", int'(done_sticky[0]), 1);
    step(4'b0, 4'b0, 4'b0001);
    check("t4_ack_clears", int'(done_sticky[0]), 0);

    // T5: clear beats a terminal strobe in the same cycle
    step(4'b0, 4'b0001, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    check("t5_count_pre", cnt(0), 2);
    step(4'b0001, 4'b0001, 4'b0);
    check("t5_count", cnt(0), 0);
    check("t5_blocks", blk(0), 0);
    check("t5_sticky", int'(done_sticky[0]), 0);

    // T6: independent channels, last_idx lowered mid-block, async reset
    last_idx = 10'd5;
    step(4'b0, 4'b1111, 4'b0);
    for (int i = 0; i < 3; i++) step(4'b0101, 4'b0, 4'b0);
    step(4'b0001, 4'b0, 4'b0);
    check("t6_ch0", cnt(0), 4);
    check("t6_ch2", cnt(2), 3);
    check("t6_ch1_ch3", cnt(1) + cnt(3), 0);
    last_idx = 10'd2;
    expect_done(2, 1);
    step(4'b0100, 4'b0, 4'b0);
    check("t6_ch2_wrap", cnt(2), 0);
    check("t6_ch0_hold", cnt(0), 4);
    check("t6_ch0_blocks", blk(0), 0);
    expect_done(0, 1);
    step(4'b0001, 4'b0, 4'b0);
    step(4'b0101, 4'b0, 4'b0);
    check("t6_mid_ch0", cnt(0), 1);
    n_rst = 1'b0;
    #2;
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_blocks", int'(blocks), 0);
    check("t6_rst_flags", int'({done, done_sticky, halted}), 0);
    @(negedge clk);
    n_rst = 1'b1;
    step(4'b0, 4'b0, 4'b0);
    step(4'b0, 4'b0, 4'b0);
    check("t6_post_rst", int'(count), 0);
    check("pending_done", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
